seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan.sv | 149 ++++++++++++++
 tb/tb_seg7_scan.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner with frame-latched (tear-free) shadow inputs.
// Optional leading-zero suppression is enabled by defining SEG_LZ_BLANK_EN.
module seg7_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] hex_in,
  input  logic [7:0]  point_in,
  input  logic [7:0]  les_in,
  output logic [7:0]  an_n,
  output logic [7:0]  seg_n,
  output logic [2:0]  digit_idx,
  output logic        frame_pulse
);

  // state    | meaning
  // ST_LOAD  | one cycle: latch shadow inputs, clear counters
  // ST_SCAN  | dwell SCAN_DIV cycles on each of digits 0..7
  typedef enum logic {ST_LOAD, ST_SCAN} state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [2:0]  digit_idx_q, digit_idx_d;
  logic [31:0] hex_q, hex_d;
  logic [7:0]  point_q, point_d;
  logic [7:0]  les_q, les_d;
  logic [7:0]  an_n_q, an_n_d;
  logic [7:0]  seg_n_q, seg_n_d;
  logic        frame_end;
  logic [3:0]  nib;
  logic [7:0]  keep;
  logic        blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

`ifdef SEG_LZ_BLANK_EN
  logic seen;

  // Walk from the top digit down; a digit stays lit once any nonzero nibble at or above it is seen.
  always_comb begin
    seen = 1'b0;
    keep = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      seen    = seen | (hex_q[4*i +: 4] != 4'h0);
      keep[i] = seen | point_q[i] | (i == 0);
    end
  end
`else
  always_comb begin
    keep = 8'hFF;
  end
`endif

  always_comb begin
    nib   = hex_q[{digit_idx_q, 2'b00} +: 4];
    blank = les_q[digit_idx_q] | ~keep[digit_idx_q];
  end

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    digit_idx_d = digit_idx_q;
    hex_d       = hex_q;
    point_d     = point_q;
    les_d       = les_q;
    an_n_d      = 8'hFF;
    seg_n_d     = 8'hFF;
    frame_end   = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        hex_d       = hex_in;
        point_d     = point_in;
        les_d       = les_in;
        div_cnt_d   = 16'd0;
        digit_idx_d = 3'd0;
        state_d     = ST_SCAN;
      end
      default: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d   = 16'd0;
          digit_idx_d = digit_idx_q + 3'd1;
          if (digit_idx_q == 3'd7) begin
            frame_end = 1'b1;
            state_d   = ST_LOAD;
          end
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
        if (!blank) begin
          an_n_d  = ~(8'b1 << digit_idx_q);
          seg_n_d = ~{point_q[digit_idx_q], hex_to_seg(nib)};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      div_cnt_q   <= 16'd0;
      digit_idx_q <= 3'd0;
      hex_q       <= 32'd0;
      point_q     <= 8'd0;
      les_q       <= 8'd0;
      an_n_q      <= 8'hFF;
      seg_n_q     <= 8'hFF;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      hex_q       <= hex_d;
      point_q     <= point_d;
      les_q       <= les_d;
      an_n_q      <= an_n_d;
      seg_n_q     <= seg_n_d;
    end
  end

  assign an_n        = an_n_q;
  assign seg_n       = seg_n_q;
  assign digit_idx   = digit_idx_q;
  assign frame_pulse = frame_end;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan at SCAN_DIV = 4: table-driven frames checked through an expectation queue,
// plus hand-written reset, periodicity and tear-free sequences.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] hex_in = '0;
  logic [7:0]  point_in = '0;
  logic [7:0]  les_in = '0;
  logic [7:0]  an_n, seg_n;
  logic [2:0]  digit_idx;
  logic        frame_pulse;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .hex_in(hex_in), .point_in(point_in), .les_in(les_in),
    .an_n(an_n), .seg_n(seg_n), .digit_idx(digit_idx), .frame_pulse(frame_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hex;
    logic [7:0]  pt;
    logic [7:0]  les;
    logic [63:0] an;   // digit 7 in the top byte
    logic [63:0] seg;
  } vec_t;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    logic [2:0] idx;
    logic       fp;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];

  localparam logic [63:0] AN_ALL  = 64'h7F_BF_DF_EF_F7_FB_FD_FE;
  localparam logic [63:0] SEG_V1  = 64'hF8_82_92_99_B0_A4_F9_C0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One frame as seen at the sampling points: a blank sample from ST_LOAD, then 8 dwells of 4.
  task automatic push_frame(input logic [63:0] an64, input logic [63:0] seg64);
    exp_t e;
    for (int k = 0; k < 33; k++) begin
      if (k == 0) begin
        e.an  = 8'hFF;
        e.seg = 8'hFF;
      end else begin
        e.an  = an64[8*((k-1)/4) +: 8];
        e.seg = seg64[8*((k-1)/4) +: 8];
      end
      e.idx = (k < 32) ? 3'(k/4) : 3'd0;
      e.fp  = (k == 31);
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string tag, input int n);
    exp_t e;
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL %s: expectation queue empty at sample %0d", tag, s);
      end else begin
        e = sb.pop_front();
        if (an_n !== e.an || seg_n !== e.seg || digit_idx !== e.idx || frame_pulse !== e.fp) begin
          n_errors++;
          $display("FAIL %s s%0d: got an=%h seg=%h idx=%0d fp=%b expected an=%h seg=%h idx=%0d fp=%b",
                   tag, s, an_n, seg_n, digit_idx, frame_pulse, e.an, e.seg, e.idx, e.fp);
        end
      end
    end
  endtask

  task automatic restart(input logic [31:0] h, input logic [7:0] p, input logic [7:0] l);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    hex_in   = h;
    point_in = p;
    les_in   = l;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int fp_pos[$];
    int fp_count;
    logic [2:0] prev_idx;
    logic load_seen;

    vecs[0] = '{32'h76543210, 8'h00, 8'h00, AN_ALL, SEG_V1};
    vecs[1] = '{32'h76543210, 8'h10, 8'h0F, 64'h7F_BF_DF_EF_FF_FF_FF_FF, 64'hF8_82_92_19_FF_FF_FF_FF};
    vecs[3] = '{32'hFEDCBA98, 8'hA5, 8'h40, 64'h7F_FF_DF_EF_F7_FB_FD_FE, 64'h0E_FF_21_C6_83_08_90_00};
`ifdef SEG_LZ_BLANK_EN
    vecs[2] = '{32'h000000A0, 8'h00, 8'h00, 64'hFF_FF_FF_FF_FF_FF_FD_FE, 64'hFF_FF_FF_FF_FF_FF_88_C0};
    vecs[4] = '{32'h00000003, 8'h20, 8'h00, 64'hFF_FF_DF_FF_FF_FF_FF_FE, 64'hFF_FF_40_FF_FF_FF_FF_B0};
`else
    vecs[2] = '{32'h000000A0, 8'h00, 8'h00, AN_ALL, 64'hC0_C0_C0_C0_C0_C0_88_C0};
    vecs[4] = '{32'h00000003, 8'h20, 8'h00, AN_ALL, 64'hC0_C0_40_C0_C0_C0_C0_B0};
`endif

    // Reset held
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an_n), 32'hFF);
    chk("rst_seg", 32'(seg_n), 32'hFF);
    chk("rst_idx", 32'(digit_idx), 32'd0);
    chk("rst_fp", 32'(frame_pulse), 32'd0);

    // Table: two back-to-back frames per vector with steady inputs
    for (int v = 0; v < 5; v++) begin
      restart(vecs[v].hex, vecs[v].pt, vecs[v].les);
      push_frame(vecs[v].an, vecs[v].seg);
      push_frame(vecs[v].an, vecs[v].seg);
      drain($sformatf("vec%0d", v), 66);
    end

    // Frame periodicity and wrap through ST_LOAD
    restart(vecs[0].hex, vecs[0].pt, vecs[0].les);
    fp_count  = 0;
    prev_idx  = 3'd0;
    load_seen = 1'b0;
    for (int s = 0; s < 100; s++) begin
      @(negedge clk);
      if (load_seen) begin
        chk("wrap_load_blank", 32'(an_n), 32'hFF);
        load_seen = 1'b0;
      end
      if (frame_pulse) begin
        fp_count++;
        fp_pos.push_back(s);
      end
      if (prev_idx == 3'd7 && digit_idx == 3'd0) load_seen = 1'b1;
      prev_idx = digit_idx;
    end
    chk("fp_count", 32'(fp_count), 32'd3);
    if (fp_pos.size() >= 3) begin
      chk("fp_period0", 32'(fp_pos[1] - fp_pos[0]), 32'd33);
      chk("fp_period1", 32'(fp_pos[2] - fp_pos[1]), 32'd33);
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL fp_positions: got %0d pulses expected 3", fp_pos.size());
    end

    // Tear-free: change hex during digit 3, visible only after the next ST_LOAD
    restart(vecs[0].hex, vecs[0].pt, vecs[0].les);
    push_frame(AN_ALL, SEG_V1);
    push_frame(AN_ALL, {8{8'h8E}});
    drain("tear_a", 14);
    hex_in = 32'hFFFFFFFF;
    drain("tear_b", 52);

    // Asynchronous reset mid-dwell
    restart(vecs[0].hex, vecs[0].pt, vecs[0].les);
    push_frame(AN_ALL, SEG_V1);
    drain("pre_async", 10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", 32'(an_n), 32'hFF);
    chk("async_seg", 32'(seg_n), 32'hFF);
    chk("async_idx", 32'(digit_idx), 32'd0);
    chk("async_fp", 32'(frame_pulse), 32'd0);
    sb.delete();

    // Restart after the async reset resumes cleanly
    restart(vecs[0].hex, vecs[0].pt, vecs[0].les);
    push_frame(AN_ALL, SEG_V1);
    drain("post_async", 33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
